ctrl_fsm: RTL
=============

Name: ctrl_fsm

Overview:
- Multi-cycle successor to the single-cycle opcode decoder in the picoMIPS control path.
- Decodes the current instruction opcode and drives ALU function, immediate select, register write and PC increment.
- Adds three behaviours: a sequential LOAD handshake with the external input switch, a parametrised multi-cycle MULI stall, and a sticky illegal-opcode trap.
- Sits between program memory output and the PC, register file and ALU control inputs.

Parameters:
- OPW, 3: opcode width; opcodes are zero-extended package constants.
- ALUFW, 2: ALU function width; ALUFunc is opcode[ALUFW-1:0].
- MUL_LAT, 2: extra stall cycles for MULI, range 0..15. 0 makes MULI single-cycle.

Ports:
- clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- opcode  input  OPW  opcode of the instruction at the current PC.
- in_valid  input  1  external input ready (switch); level-sensitive.
- ALUFunc  output  ALUFW  ALU function select.
- imm  output  1  1 selects immediate/external operand, 0 selects register.
- write  output  1  register-file write enable.
- PCincr  output  1  advance PC this cycle.
- in_ack  output  1  external input sampled this cycle.
- busy  output  1  state is not EXEC.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- Opcodes: NOP=000, ADDI=001, ADD=010, MULI=011, LOAD=100, HALT=111. All others are illegal.
- States: EXEC, MUL_WAIT, LOAD_WAIT, LOAD_REL, TRAP. 4-bit stall counter cnt.
- nReset low, asynchronous:
  - State goes to EXEC and cnt to 0.
  - All outputs are forced 0, including ALUFunc, via combinational gating on nReset.
- Outputs are combinational from (state, opcode, in_valid, cnt). State and cnt are registered; there is no output latency.
- ALUFunc = opcode[ALUFW-1:0] in every non-TRAP state. It is 0 in TRAP.
- EXEC:
  - NOP: PCincr=1.
  - ADD: write=1, PCincr=1, imm=0.
  - ADDI: write=1, imm=1, PCincr=1.
  - MULI with MUL_LAT=0: same as ADDI.
  - MULI with MUL_LAT>0: imm=1, write=0, PCincr=0; load cnt=MUL_LAT; go to MUL_WAIT.
  - LOAD: imm=1, write=0, PCincr=0; go to LOAD_WAIT, even if in_valid is already 1.
  - HALT: all enables 0; stay in EXEC (PC frozen).
  - Illegal opcode: go to TRAP; no write, no PCincr in that cycle.
- MUL_WAIT:
  - imm=1 throughout; cnt decrements each cycle.
  - When cnt==1: write=1, PCincr=1, next state EXEC.
  - MULI therefore occupies MUL_LAT+1 cycles and writes exactly once, on the last cycle.
- LOAD_WAIT:
  - imm=1.
  - When in_valid=1: write=1, in_ack=1 for exactly one cycle, next state LOAD_REL.
  - Otherwise hold.
- LOAD_REL:
  - Waits for in_valid=0.
  - On that cycle: PCincr=1, next state EXEC.
  - write stays 0, so one switch press loads exactly once.
- TRAP: illegal=1; all enables 0. Exit only via nReset.
- opcode changing mid-stall (e.g. memory glitch) is ignored: stall states latch nothing from opcode except ALUFunc/imm, which keep their values.
- Reset asserted mid-stall aborts the instruction: no write, PC not advanced.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined:
  - Extra output port retired [15:0], reset to 0.
  - Increments by 1 on every cycle with PCincr=1; wraps 16'hFFFF to 0.
  - Held in TRAP and HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- ctrl_pkg holds the opcode localparams (NOP, ADDI, ADD, MULI, LOAD, HALT), the state_t enum and the default OPW/ALUFW.
- One sub-module, stall_counter: 4-bit loadable down-counter with a load strobe, dec strobe and a one_o flag (cnt==1). It shares the clk/nReset style.

Test Plan:
- Reset → ADDI, ADD, NOP sequence → PCincr=1 every cycle; write=1,0-imm/1-imm as specified; busy=0 throughout.
- MULI with MUL_LAT=2 → cycles 1-2 have write=0, PCincr=0, busy=1; cycle 3 has write=1, PCincr=1, imm=1. Repeat with MUL_LAT=0 → single cycle.
- LOAD with in_valid low for 5 cycles, high for 3, then low → exactly one write/in_ack pulse on the first high cycle; PCincr only on the first low cycle after; total 10 cycles.
- Opcode 101 → illegal=1 sticky; no write/PCincr for 20 cycles despite valid opcodes; nReset pulse clears it.
- nReset asserted in MUL_WAIT at cnt=1 → outputs 0 immediately; after release, state is EXEC and no write occurred.
- With CTRL_PERF_CNT_EN: run 5 NOPs, then a LOAD handshake, then HALT for 10 cycles → retired=6 and holds.

Source files
------------

// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the picoMIPS multi-cycle control FSM (ctrl_fsm).
// Holds the opcode constants, the FSM state encoding and the default widths.
package ctrl_pkg;

   localparam int OPW_DEF   = 3;
   localparam int ALUFW_DEF = 2;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] ADDI = 3'b001;
   localparam logic [2:0] ADD  = 3'b010;
   localparam logic [2:0] MULI = 3'b011;
   localparam logic [2:0] LOAD = 3'b100;
   localparam logic [2:0] HALT = 3'b111;

   typedef enum logic [2:0] {
      EXEC      = 3'd0,
      MUL_WAIT  = 3'd1,
      LOAD_WAIT = 3'd2,
      LOAD_REL  = 3'd3,
      TRAP      = 3'd4
   } state_t;

endpackage : ctrl_pkg

// File: rtl/ctrl_fsm_if.sv
// Instruction/control bundle between program memory, input switch and ctrl_fsm.
// master = the control FSM, slave = the surrounding datapath/environment.
interface ctrl_fsm_if
   import ctrl_pkg::*;
#(
   parameter int OPW   = OPW_DEF,
   parameter int ALUFW = ALUFW_DEF
) ();

   logic [OPW-1:0]   opcode;
   logic             in_valid;
   logic [ALUFW-1:0] ALUFunc;
   logic             imm;
   logic             write;
   logic             PCincr;
   logic             in_ack;
   logic             busy;
   logic             illegal;

   modport master (
      input  opcode, in_valid,
      output ALUFunc, imm, write, PCincr, in_ack, busy, illegal
   );

   modport slave (
      output opcode, in_valid,
      input  ALUFunc, imm, write, PCincr, in_ack, busy, illegal
   );

endinterface : ctrl_fsm_if

// File: rtl/ctrl_fsm_stall_counter.sv
// 4-bit loadable down-counter used to time the MULI stall.
// Load has priority over decrement; the counter never wraps below zero.
module stall_counter (
   input  logic       clk,
   input  logic       nReset,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic       one_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // next count: load, saturating decrement, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign one_o = (cnt_q == 4'd1);

endmodule : stall_counter

// File: rtl/ctrl_fsm.sv
// picoMIPS multi-cycle control FSM: decode, MULI stall, LOAD handshake, illegal trap.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int OPW     = OPW_DEF,
   parameter int ALUFW   = ALUFW_DEF,
   parameter int MUL_LAT = 2
) (
   input  logic       clk,
   input  logic       nReset,
   ctrl_fsm_if.master bus
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [15:0] retired
`endif
);

   state_t           state_q;
   state_t           state_d;
   logic [ALUFW-1:0] func_q;
   logic [ALUFW-1:0] func_d;

   logic [ALUFW-1:0] alu_s;
   logic             imm_s;
   logic             write_s;
   logic             pcincr_s;
   logic             ack_s;
   logic             illegal_s;
   logic             cnt_load_s;
   logic             cnt_dec_s;
   logic             cnt_one_s;

   stall_counter u_stall_counter (
      .clk        (clk),
      .nReset     (nReset),
      .load_i     (cnt_load_s),
      .load_val_i (4'(MUL_LAT)),
      .dec_i      (cnt_dec_s),
      .one_o      (cnt_one_s)
   );

   // next state and ungated control outputs
   always_comb begin
      state_d    = state_q;
      func_d     = func_q;
      alu_s      = '0;
      imm_s      = 1'b0;
      write_s    = 1'b0;
      pcincr_s   = 1'b0;
      ack_s      = 1'b0;
      illegal_s  = 1'b0;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
      case (state_q)
         EXEC: begin
            alu_s  = bus.opcode[ALUFW-1:0];
            func_d = bus.opcode[ALUFW-1:0];
            case (bus.opcode)
               OPW'(NOP): begin
                  pcincr_s = 1'b1;
               end
               OPW'(ADD): begin
                  write_s  = 1'b1;
                  pcincr_s = 1'b1;
               end
               OPW'(ADDI): begin
                  imm_s    = 1'b1;
                  write_s  = 1'b1;
                  pcincr_s = 1'b1;
               end
               OPW'(MULI): begin
                  imm_s = 1'b1;
                  if (MUL_LAT == 0) begin
                     write_s  = 1'b1;
                     pcincr_s = 1'b1;
                  end else begin
                     cnt_load_s = 1'b1;
                     state_d    = MUL_WAIT;
                  end
               end
               OPW'(LOAD): begin
                  imm_s   = 1'b1;
                  state_d = LOAD_WAIT;
               end
               OPW'(HALT): begin
                  state_d = EXEC;
               end
               default: begin
                  state_d = TRAP;
               end
            endcase
         end
         // stall states replay the latched function so opcode glitches are ignored
         MUL_WAIT: begin
            alu_s     = func_q;
            imm_s     = 1'b1;
            cnt_dec_s = 1'b1;
            if (cnt_one_s) begin
               write_s  = 1'b1;
               pcincr_s = 1'b1;
               state_d  = EXEC;
            end else begin
               state_d = MUL_WAIT;
            end
         end
         LOAD_WAIT: begin
            alu_s = func_q;
            imm_s = 1'b1;
            if (bus.in_valid) begin
               write_s = 1'b1;
               ack_s   = 1'b1;
               state_d = LOAD_REL;
            end else begin
               state_d = LOAD_WAIT;
            end
         end
         LOAD_REL: begin
            alu_s = func_q;
            imm_s = 1'b1;
            if (!bus.in_valid) begin
               pcincr_s = 1'b1;
               state_d  = EXEC;
            end else begin
               state_d = LOAD_REL;
            end
         end
         TRAP: begin
            illegal_s = 1'b1;
            state_d   = TRAP;
         end
         default: begin
            illegal_s = 1'b1;
            state_d   = TRAP;
         end
      endcase
   end

   // state and latched ALU function
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= EXEC;
         func_q  <= '0;
      end else begin
         state_q <= state_d;
         func_q  <= func_d;
      end
   end

   // outputs forced low while reset is asserted, even mid-instruction
   always_comb begin
      if (nReset) begin
         bus.ALUFunc = alu_s;
         bus.imm     = imm_s;
         bus.write   = write_s;
         bus.PCincr  = pcincr_s;
         bus.in_ack  = ack_s;
         bus.busy    = (state_q != EXEC);
         bus.illegal = illegal_s;
      end else begin
         bus.ALUFunc = '0;
         bus.imm     = 1'b0;
         bus.write   = 1'b0;
         bus.PCincr  = 1'b0;
         bus.in_ack  = 1'b0;
         bus.busy    = 1'b0;
         bus.illegal = 1'b0;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [15:0] retired_q;
   logic [15:0] retired_d;

   // retired count follows PC advances, so TRAP and HALT hold it
   always_comb begin
      if (pcincr_s) begin
         retired_d = retired_q + 16'd1;
      end else begin
         retired_d = retired_q;
      end
   end

   // retired counter register
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         retired_q <= 16'd0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;
`endif

endmodule : ctrl_fsm
